// File: rtl/opamp_seo_array.sv
// Per-channel op-amp / comparator array with rail clamping and optional output slew limiting.
// Define OPAMP_SEO_SLEW_LIMIT_EN to ramp outputs by at most SLEW per cycle; otherwise they jump.
module opamp_seo_array #(
  parameter int unsigned W          = 12,
  parameter int unsigned CH         = 4,
  parameter int unsigned GAIN_SHIFT = 2,
  parameter int unsigned SLEW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] in_plus,
  input  logic [CH*W-1:0] in_minus,
  input  logic [W-1:0]    v_plus,
  input  logic [W-1:0]    v_minus,
  input  logic            mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*W-1:0] out_neutral,
  output logic [CH-1:0]   sat
);

  localparam int unsigned DW = W + 1;
  localparam int unsigned TW = W + 1 + GAIN_SHIFT;

  typedef enum logic [1:0] {StIdle, StCompute, StSettle, StHold} state_e;

  state_e state_q, state_d;

  logic [CH*W-1:0]     in_plus_q, in_plus_d, in_minus_q, in_minus_d;
  logic signed [W-1:0] v_plus_q, v_plus_d, v_minus_q, v_minus_d;
  logic                mode_q, mode_d;
  logic signed [W-1:0] target_q [CH];
  logic signed [W-1:0] target_d [CH];
  logic signed [W-1:0] out_q [CH];
  logic signed [W-1:0] out_d [CH];
  logic [CH-1:0]       sat_q, sat_d;

  logic signed [DW-1:0] diff [CH];
  logic signed [TW-1:0] amp [CH];
  logic signed [W-1:0]  tgt [CH];
  logic [CH-1:0]        sat_c;
  logic                 fault;
  logic signed [TW-1:0] vp_w, vm_w;

`ifdef OPAMP_SEO_SLEW_LIMIT_EN
  localparam logic signed [DW:0] SlewS = $signed((DW + 1)'(SLEW));
  logic all_eq;
`else
  logic loaded_q, loaded_d;
`endif

  // Target evaluation from the captured sample; used only in StCompute.
  always_comb begin
    fault = v_minus_q > v_plus_q;
    vp_w  = TW'(v_plus_q);
    vm_w  = TW'(v_minus_q);
    sat_c = '0;
    for (int c = 0; c < CH; c++) begin
      diff[c] = DW'($signed(in_plus_q[c*W +: W])) - DW'($signed(in_minus_q[c*W +: W]));
      amp[c]  = TW'(diff[c]) <<< GAIN_SHIFT;
      tgt[c]  = out_q[c];
      if (fault) begin
        tgt[c]   = '0;
        sat_c[c] = 1'b1;
      end else if (!mode_q) begin
        if (amp[c] > vp_w) begin
          tgt[c]   = v_plus_q;
          sat_c[c] = 1'b1;
        end else if (amp[c] < vm_w) begin
          tgt[c]   = v_minus_q;
          sat_c[c] = 1'b1;
        end else begin
          tgt[c] = amp[c][W-1:0];
        end
      end else if (diff[c] > 0) begin
        tgt[c]   = v_plus_q;
        sat_c[c] = 1'b1;
      end else if (diff[c] < 0) begin
        tgt[c]   = v_minus_q;
        sat_c[c] = 1'b1;
      end
    end
  end

`ifdef OPAMP_SEO_SLEW_LIMIT_EN
  always_comb begin
    all_eq = 1'b1;
    for (int c = 0; c < CH; c++) begin
      if (out_q[c] != target_q[c]) all_eq = 1'b0;
    end
  end
`endif

  always_comb begin
`ifdef OPAMP_SEO_SLEW_LIMIT_EN
    logic signed [DW:0] dist;
    dist = '0;
`else
    loaded_d = 1'b0;
`endif
    in_plus_d  = in_plus_q;
    in_minus_d = in_minus_q;
    v_plus_d   = v_plus_q;
    v_minus_d  = v_minus_q;
    mode_d     = mode_q;
    sat_d      = sat_q;
    for (int c = 0; c < CH; c++) begin
      target_d[c] = target_q[c];
      out_d[c]    = out_q[c];
    end
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          in_plus_d  = in_plus;
          in_minus_d = in_minus;
          v_plus_d   = v_plus;
          v_minus_d  = v_minus;
          mode_d     = mode;
        end
      end
      StCompute: begin
        sat_d = sat_c;
        for (int c = 0; c < CH; c++) target_d[c] = tgt[c];
      end
      StSettle: begin
`ifdef OPAMP_SEO_SLEW_LIMIT_EN
        for (int c = 0; c < CH; c++) begin
          dist = (DW + 1)'(target_q[c]) - (DW + 1)'(out_q[c]);
          if (dist > SlewS)       out_d[c] = out_q[c] + SlewS[W-1:0];
          else if (dist < -SlewS) out_d[c] = out_q[c] - SlewS[W-1:0];
          else                    out_d[c] = target_q[c];
        end
`else
        // First SETTLE cycle loads, second hands over to HOLD: fixed latency.
        loaded_d = 1'b1;
        if (!loaded_q) begin
          for (int c = 0; c < CH; c++) out_d[c] = target_q[c];
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      in_plus_q  <= '0;
      in_minus_q <= '0;
      v_plus_q   <= '0;
      v_minus_q  <= '0;
      mode_q     <= 1'b0;
      sat_q      <= '0;
      for (int c = 0; c < CH; c++) begin
        target_q[c] <= '0;
        out_q[c]    <= '0;
      end
`ifndef OPAMP_SEO_SLEW_LIMIT_EN
      loaded_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      in_plus_q  <= in_plus_d;
      in_minus_q <= in_minus_d;
      v_plus_q   <= v_plus_d;
      v_minus_q  <= v_minus_d;
      mode_q     <= mode_d;
      sat_q      <= sat_d;
      for (int c = 0; c < CH; c++) begin
        target_q[c] <= target_d[c];
        out_q[c]    <= out_d[c];
      end
`ifndef OPAMP_SEO_SLEW_LIMIT_EN
      loaded_q <= loaded_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_valid) state_d = StCompute;
      StCompute: state_d = StSettle;
`ifdef OPAMP_SEO_SLEW_LIMIT_EN
      StSettle:  if (all_eq) state_d = StHold;
`else
      StSettle:  if (loaded_q) state_d = StHold;
`endif
      StHold:    if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are forced quiet combinationally for as long as rst is held.
  always_comb begin
    in_ready    = (state_q == StIdle) && !rst;
    out_valid   = (state_q == StHold) && !rst;
    sat         = rst ? '0 : sat_q;
    out_neutral = '0;
    for (int c = 0; c < CH; c++) begin
      out_neutral[c*W +: W] = rst ? '0 : out_q[c];
    end
  end

endmodule

// File: tb/tb_opamp_seo_array.sv
// Directed, table-driven bench for opamp_seo_array; expectations follow OPAMP_SEO_SLEW_LIMIT_EN.
module tb_opamp_seo_array;

  localparam int W  = 12;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CH*W-1:0] in_plus = '0;
  logic [CH*W-1:0] in_minus = '0;
  logic [W-1:0]    v_plus = '0;
  logic [W-1:0]    v_minus = '0;
  logic            mode = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CH*W-1:0] out_neutral;
  logic [CH-1:0]   sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  opamp_seo_array #(
    .W(W), .CH(CH), .GAIN_SHIFT(2), .SLEW(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_plus(in_plus), .in_minus(in_minus), .v_plus(v_plus), .v_minus(v_minus),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_neutral(out_neutral), .sat(sat)
  );

  typedef struct {
    logic        md;
    logic [47:0] ip;
    logic [47:0] im;
    logic [11:0] vp;
    logic [11:0] vm;
    logic [47:0] eo;
    logic [3:0]  es;
    int          lat;  // accept-to-out_valid cycles when slew limiting is enabled
  } vec_t;

  vec_t tbl [8];

  function automatic logic [47:0] pk(input int a, input int b, input int c, input int d);
    logic [11:0] ta, tb2, tc, td;
    ta = a[11:0]; tb2 = b[11:0]; tc = c[11:0]; td = d[11:0];
    return {td, tc, tb2, ta};
  endfunction

  function automatic vec_t mk(input logic md, input int p0, input int p1, input int p2,
                              input int p3, input int m0, input int m1, input int m2,
                              input int m3, input int vp, input int vm, input int o0,
                              input int o1, input int o2, input int o3,
                              input logic [3:0] s, input int lat);
    vec_t v;
    v.md = md;
    v.ip = pk(p0, p1, p2, p3);
    v.im = pk(m0, m1, m2, m3);
    v.vp = vp[11:0];
    v.vm = vm[11:0];
    v.eo = pk(o0, o1, o2, o3);
    v.es = s;
    v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_plus  = v.ip;
    in_minus = v.im;
    v_plus   = v.vp;
    v_minus  = v.vm;
    mode     = v.md;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int cyc;
    int exp_lat;
    drive(v);
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check($sformatf("v%0d_in_ready", idx), in_ready, 1);
    @(posedge clk); #1;
    // Scramble inputs after accept; the captured sample must be unaffected.
    in_valid = 1'b0;
    in_plus  = '1;
    in_minus = '0;
    mode     = ~mode;
    v_plus   = '0;
    v_minus  = '0;
    cyc = 1;
    while (!out_valid && cyc < 400) begin
      @(posedge clk); #1; cyc++;
    end
`ifdef OPAMP_SEO_SLEW_LIMIT_EN
    exp_lat = v.lat;
`else
    exp_lat = 4;
`endif
    check($sformatf("v%0d_latency", idx), cyc, exp_lat);
    check($sformatf("v%0d_out", idx), out_neutral, v.eo);
    check($sformatf("v%0d_sat", idx), sat, v.es);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("v%0d_idle_ready", idx), in_ready, 1);
    check($sformatf("v%0d_idle_valid", idx), out_valid, 0);
    check($sformatf("v%0d_idle_out", idx), out_neutral, v.eo);
  endtask

  initial begin
    int cyc;
    vec_t h;
    // mode, in_plus ch0..3, in_minus ch0..3, v_plus, v_minus, out ch0..3, sat, slew latency
    tbl[0] = mk(0, 100, 10, -20, 0, 50, 0, 0, 0, 1000, -1000, 200, 40, -80, 0, 4'b0000, 28);
    tbl[1] = mk(0, 600, 0, -300, 250, 0, 0, 0, 0, 1000, -1000,
                1000, 0, -1000, 1000, 4'b0101, 128);
    tbl[2] = mk(1, 0, 5, 7, 3, 1, 5, 2, 3, 1000, -1000, -1000, 0, 1000, 1000, 4'b0101, 253);
    tbl[3] = mk(1, 3, 3, 3, 3, 3, 3, 3, 3, 1000, -1000, -1000, 0, 1000, 1000, 4'b0000, 3);
    tbl[4] = mk(0, 100, 200, -50, 7, 0, 0, 0, 0, -5, 5, 0, 0, 0, 0, 4'b1111, 128);
    tbl[5] = mk(1, 9, -9, 0, 1, 0, 0, 0, 0, -5, 5, 0, 0, 0, 0, 4'b1111, 3);
    tbl[6] = mk(0, 30, -30, 10, -10, 0, 0, 0, 0, 100, -50, 100, -50, 40, -40, 4'b0011, 16);
    tbl[7] = mk(0, 2047, -2048, -2048, 0, -2048, 2047, -2048, -1, 1000, -1000,
                1000, -1000, 0, 4, 4'b0011, 122);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out_neutral, 0);
    check("rst_sat", sat, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) run_txn(i, tbl[i]);

    // Stall in HOLD: outputs frozen, new offers ignored.
    h = mk(0, 1, 2, 3, 4, 0, 0, 0, 0, 1000, -1000, 4, 8, 12, 16, 4'b0000, 0);
    drive(h);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 400) begin
      @(posedge clk); #1; cyc++;
    end
    check("hold_reached", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_plus  = {4{12'h123}};
      in_minus = {4{12'h7ff}};
      mode     = ~mode;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_out", out_neutral, h.eo);
      check("hold_sat", sat, 0);
      check("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release_ready", in_ready, 1);
    check("hold_release_out", out_neutral, h.eo);

    // Reset while settling aborts with no result.
    h = mk(0, 600, -600, 0, 0, 0, 0, 0, 0, 1000, -1000, 1000, -1000, 0, 0, 4'b0011, 0);
    drive(h);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_comb_out", out_neutral, 0);
    check("abort_comb_ready", in_ready, 0);
    @(posedge clk); #1;
    check("abort_out", out_neutral, 0);
    check("abort_sat", sat, 0);
    check("abort_valid", out_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", in_ready, 1);
    check("abort_out_idle", out_neutral, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/opamp_seo_array.md
OPAMP_SEO_ARRAY -- requirements
Module: opamp_seo_array

Interface
REQ-001 Parameters (name, default, meaning): W, 12, signed sample width; CH, 4, channel count; GAIN_SHIFT, 2, amplifier gain as 2**GAIN_SHIFT; SLEW, 8, max output step per cycle (unsigned, >=1).
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_plus  in  CH*W  signed non-inverting inputs; channel c is bits [c*W +: W].
- in_minus  in  CH*W  signed inverting inputs.
- v_plus  in  W  signed upper rail.
- v_minus  in  W  signed lower rail.
- mode  in  1  0 = amplifier, 1 = comparator; sampled on accept.
- out_valid  out  1  settled result available.
- out_ready  in  1  consumer takes result.
- out_neutral  out  CH*W  signed per-channel output.
- sat  out  CH  per-channel saturation or rail-fault flag.
REQ-003 The block SHALL use one clock, clk, with reset rst synchronous and active-high.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, COMPUTE, SETTLE and HOLD.
REQ-005 in_ready SHALL be 1 only in IDLE; the handshake in_valid&in_ready SHALL register in_plus, in_minus, v_plus, v_minus and mode, then enter COMPUTE.
REQ-006 COMPUTE SHALL last one cycle, then enter SETTLE.
REQ-007 COMPUTE SHALL calculate diff = in_plus - in_minus per channel at W+1 bits, sign-extended.
REQ-008 In amplifier mode, COMPUTE SHALL form target = diff <<< GAIN_SHIFT at W+1+GAIN_SHIFT bits, with no overflow.
REQ-009 In amplifier mode, the target SHALL then be clamped to [v_minus, v_plus]; sat[c] = 1 if clamping occurred, else 0.
REQ-010 In comparator mode, target SHALL be v_plus if diff>0 and v_minus if diff<0; sat[c] = 1 for diff != 0.
REQ-011 In comparator mode with diff==0, target SHALL equal the current out_neutral[c] and sat[c] SHALL be 0.
REQ-012 If v_minus > v_plus, every channel target SHALL be 0 and every sat bit 1, in both modes.
REQ-013 In SETTLE, each cycle, each channel whose output is not at its target SHALL move toward the target by min(SLEW, |target-out|).
REQ-014 SETTLE SHALL exit to HOLD in the cycle after all channels equal their targets.
REQ-015 out_valid SHALL be 1 only in HOLD; out_neutral and sat SHALL stay stable in HOLD.
REQ-016 HOLD with out_ready=1 SHALL return to IDLE next cycle; out_neutral SHALL keep its value through IDLE.
REQ-017 Latency: accept at cycle N, COMPUTE at N+1, SETTLE from N+2, out_valid at N+2+ceil(max|target-out|/SLEW)+1.
REQ-018 in_valid outside IDLE SHALL be ignored; input changes after accept SHALL have no effect.

Reset
REQ-019 While rst=1, out_neutral SHALL be 0, sat 0, out_valid 0 and in_ready 0.
REQ-020 After rst, the state SHALL be IDLE, so in_ready=1 the cycle after rst deasserts.
REQ-021 rst in any state SHALL abort the operation with no partial result presented.

Configuration
REQ-022 Macro OPAMP_SEO_SLEW_LIMIT_EN, when defined, SHALL enable REQ-013 slew limiting.
REQ-023 When OPAMP_SEO_SLEW_LIMIT_EN is undefined, SETTLE SHALL load out_neutral = target in one cycle and go to HOLD next; latency is fixed at 4 cycles from accept to out_valid; SLEW SHALL be unused.

Verification
Settings: W=12, GAIN_SHIFT=2, SLEW=8, v_plus=1000, v_minus=-1000, macro defined unless stated.
REQ-024 Amplifier, ch0 in_plus=100, in_minus=50, start out=0 -> out_neutral ramps 0,8,...,200 in 25 SETTLE cycles; out_valid at accept+28; sat[0]=0.
REQ-025 Amplifier, in_plus=600, in_minus=0 -> target 1000, sat=1; with macro undefined, out_neutral=1000 and out_valid at accept+4.
REQ-026 Comparator: diff=-1 -> out_neutral=-1000, sat=1; next sample diff=0 -> out_neutral stays -1000, sat=0.
REQ-027 HOLD with out_ready=0 for 10 cycles -> out_valid stays 1, out_neutral stable, in_ready 0, in_valid pulses ignored.
REQ-028 rst during SETTLE -> next cycle out_neutral=0, sat=0, out_valid=0; in_ready=1 after rst drops.
REQ-029 v_plus=-5, v_minus=5 -> all out_neutral=0, sat all 1, both modes.
